mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/address width in bits.
REQ-002 SHALL have parameter STRB_W, default DATA_W/8, byte-strobe width.
REQ-003 Ports, in this order:
  clk  in  1  sole clock; all logic on rising edge
  rst  in  1  reset, synchronous, active-high
  if_req  in  1  fetch read request, level, held until if_done
  if_addr  in  DATA_W  fetch byte address
  if_rdata  out  DATA_W  fetch read data, valid with if_done
  if_done  out  1  one-cycle completion pulse for fetch
  if_err  out  1  rresp != OKAY, valid with if_done
  d_req  in  1  data-port request, level, held until d_done
  d_we  in  1  1 = store, 0 = load
  d_addr  in  DATA_W  data byte address
  d_wdata  in  DATA_W  store data, already lane-aligned
  d_wstrb  in  STRB_W  store byte strobes
  d_rdata  out  DATA_W  load data, valid with d_done
  d_done  out  1  one-cycle completion pulse for data port
  d_err  out  1  rresp/bresp != OKAY, valid with d_done
  axi_araddr, axi_arvalid, axi_arready, axi_rdata, axi_rresp, axi_rvalid, axi_rready, axi_awaddr, axi_awvalid, axi_awready, axi_wdata, axi_wstrb, axi_wvalid, axi_wready, axi_bresp, axi_bvalid, axi_bready  AXI4-Lite master; standard directions and widths (resp 2, strb STRB_W)
  axi_arprot, axi_awprot  out  3  tied 3'b000
REQ-004 SHALL drive all outputs from registers; no combinational path from input to output.

Function
REQ-005 SHALL implement FSM states IDLE, AR, R, AW_W, B, RESP.
REQ-006 IDLE: if any request, SHALL grant one, latch its addr (with [1:0] forced 0), wdata, wstrb, we and grant id, and go to AR (read) or AW_W (store) next cycle.
REQ-007 Arbitration SHALL be round-robin: if both if_req and d_req high in IDLE, grant the port not granted last; last-grant register resets to fetch, so data wins the first tie.
REQ-008 Only the requester at IDLE-time is granted; request changes during a transaction SHALL be ignored.
REQ-009 AR: axi_arvalid=1 with latched address; on arready go to R with axi_rready=1, arvalid=0.
REQ-010 R: on rvalid&rready latch rdata and err=(rresp!=0), drop rready, go to RESP.
REQ-011 AW_W: axi_awvalid and axi_wvalid asserted in same cycle; each deasserts independently on its own handshake; SHALL go to B once both completed, including same-cycle completion; neither reasserted once done.
REQ-012 B: axi_bready=1; on bvalid latch err=(bresp!=0), drop bready, go to RESP.
REQ-013 RESP: granted port's done pulses exactly one cycle with rdata/err; stores return rdata=0; non-granted done SHALL be 0; next state IDLE.
REQ-014 IDLE is entered for one cycle after RESP, so a request held through the done cycle is not reissued; requester SHALL drop req on the cycle after done unless issuing a new access.
REQ-015 Minimum read latency req->done: 4 cycles with arready and rvalid both high at first opportunity; write likewise 4 cycles.
REQ-016 Error responses SHALL not abort or retry; transaction completes normally with err=1.

Reset
REQ-017 With rst=1 at a clock edge: state IDLE; all axi_*valid/ready outputs 0; addr/data/strb outputs 0; if_done, d_done, errs, rdata 0; last-grant = fetch.
REQ-018 Reset mid-transaction SHALL abandon it with no done pulse; the interconnect is reset alongside.

Structure
REQ-019 State enum, AXI resp codes (OKAY=2'b00) and grant-id encoding SHALL live in the shared def package.
REQ-020 Single module; no sub-module; core top instantiates it between fetch/MEM stages and the MMU bus.

Verification
REQ-021 Fetch read, if_addr=0x1003, zero-wait slave returns 0xDEADBEEF -> araddr=0x1000, if_done at cycle 4, if_rdata=0xDEADBEEF, if_err=0.
REQ-022 Both req same cycle twice in a row -> first grant data, second grant fetch; each done pulses once.
REQ-023 Store d_wdata=0x0000AB00, d_wstrb=4'b0010, awready 3 cycles before wready -> awvalid drops first, wvalid held until wready, one d_done, no reissue.
REQ-024 Load with rresp=2'b10 -> d_done with d_err=1, FSM back to IDLE.
REQ-025 rst asserted while in R -> next cycle rready=0, state IDLE, no done pulse; following fetch completes normally.
REQ-026 d_req held high through d_done and one extra cycle -> exactly two transactions, never overlapping.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data to AXI4-Lite memory arbiter:
// FSM states, AXI response codes and grant identifiers.
`timescale 1ns/1ps
package mem_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      AR,
      R,
      AW_W,
      B,
      RESP
   } state_e;

   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_DATA  = 1'b1
   } gnt_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // On a tie the port that did not win last time is served.
   function automatic gnt_e pick_grant(input logic if_req, input logic d_req, input gnt_e last);
      if (if_req && d_req) begin
         return (last == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
      end
      return d_req ? GNT_DATA : GNT_FETCH;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling the fetch read port and the data load/store
// port onto a single AXI4-Lite master, one transaction at a time.
`timescale 1ns/1ps
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [DATA_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [DATA_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [STRB_W-1:0] d_wstrb,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_err,
   output logic [DATA_W-1:0] axi_araddr,
   output logic              axi_arvalid,
   input  logic              axi_arready,
   input  logic [DATA_W-1:0] axi_rdata,
   input  logic [1:0]        axi_rresp,
   input  logic              axi_rvalid,
   output logic              axi_rready,
   output logic [DATA_W-1:0] axi_awaddr,
   output logic              axi_awvalid,
   input  logic              axi_awready,
   output logic [DATA_W-1:0] axi_wdata,
   output logic [STRB_W-1:0] axi_wstrb,
   output logic              axi_wvalid,
   input  logic              axi_wready,
   input  logic [1:0]        axi_bresp,
   input  logic              axi_bvalid,
   output logic              axi_bready,
   output logic [2:0]        axi_arprot,
   output logic [2:0]        axi_awprot
);

   state_e            state_q;
   gnt_e              gnt_q;
   gnt_e              last_gnt_q;
   logic [DATA_W-1:0] araddr_q;
   logic              arvalid_q;
   logic              rready_q;
   logic [DATA_W-1:0] awaddr_q;
   logic              awvalid_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;
   logic              wvalid_q;
   logic              bready_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              if_done_q;
   logic              d_done_q;

   gnt_e              grant_d;
   logic              store_d;
   logic [DATA_W-1:0] addr_d;

   assign grant_d = pick_grant(if_req, d_req, last_gnt_q);
   assign store_d = (grant_d == GNT_DATA) && d_we;
   assign addr_d  = ((grant_d == GNT_DATA) ? d_addr : if_addr) & ~DATA_W'(3);

   // Every output comes straight from a register updated on the state transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= GNT_FETCH;
         last_gnt_q <= GNT_FETCH;
         araddr_q   <= '0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         awaddr_q   <= '0;
         awvalid_q  <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         if_done_q  <= 1'b0;
         d_done_q   <= 1'b0;
      end else begin
         if_done_q <= 1'b0;
         d_done_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (if_req || d_req) begin
                  gnt_q      <= grant_d;
                  last_gnt_q <= grant_d;
                  if (store_d) begin
                     awaddr_q  <= addr_d;
                     wdata_q   <= d_wdata;
                     wstrb_q   <= d_wstrb;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= AW_W;
                  end else begin
                     araddr_q  <= addr_d;
                     arvalid_q <= 1'b1;
                     state_q   <= AR;
                  end
               end
            end
            AR: begin
               if (axi_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= R;
               end
            end
            R: begin
               if (axi_rvalid) begin
                  rdata_q   <= axi_rdata;
                  err_q     <= (axi_rresp != RESP_OKAY);
                  rready_q  <= 1'b0;
                  if_done_q <= (gnt_q == GNT_FETCH);
                  d_done_q  <= (gnt_q == GNT_DATA);
                  state_q   <= RESP;
               end
            end
            AW_W: begin
               // Address and data channels retire independently, possibly together.
               if (awvalid_q && axi_awready) awvalid_q <= 1'b0;
               if (wvalid_q && axi_wready) wvalid_q <= 1'b0;
               if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) begin
                  bready_q <= 1'b1;
                  state_q  <= B;
               end
            end
            B: begin
               if (axi_bvalid) begin
                  rdata_q   <= '0;
                  err_q     <= (axi_bresp != RESP_OKAY);
                  bready_q  <= 1'b0;
                  if_done_q <= (gnt_q == GNT_FETCH);
                  d_done_q  <= (gnt_q == GNT_DATA);
                  state_q   <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign if_rdata    = rdata_q;
   assign d_rdata     = rdata_q;
   assign if_err      = err_q;
   assign d_err       = err_q;
   assign if_done     = if_done_q;
   assign d_done      = d_done_q;
   assign axi_araddr  = araddr_q;
   assign axi_arvalid = arvalid_q;
   assign axi_rready  = rready_q;
   assign axi_awaddr  = awaddr_q;
   assign axi_awvalid = awvalid_q;
   assign axi_wdata   = wdata_q;
   assign axi_wstrb   = wstrb_q;
   assign axi_wvalid  = wvalid_q;
   assign axi_bready  = bready_q;
   assign axi_arprot  = 3'b000;
   assign axi_awprot  = 3'b000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model of grants, AXI handshakes and completions.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        if_err;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        d_err;
   logic [31:0] axi_araddr;
   logic        axi_arvalid;
   logic        axi_arready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rvalid;
   logic        axi_rready;
   logic [31:0] axi_awaddr;
   logic        axi_awvalid;
   logic        axi_awready;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wvalid;
   logic        axi_wready;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready;
   logic [2:0]  axi_arprot;
   logic [2:0]  axi_awprot;

   int assertCount = 0;
   int failCount   = 0;

   // Slave behaviour knobs
   int          readyPct    = 100;
   int          errPct      = 0;
   int          rHold       = 0;
   int          wHold       = 0;
   bit          forceRdEn   = 0;
   logic [31:0] forceRdata  = 32'h0;
   bit          forceRespEn = 0;
   logic [1:0]  forceResp   = 2'b00;

   // Model state
   int          phase = 2;
   bit          lastGntData = 0;
   bit          gntData = 0;
   bit          expWe = 0;
   logic [31:0] expAddr, expWdata, expRdata;
   logic [3:0]  expWstrb;
   bit          expErr;
   int          arCnt, rCnt, awCnt, wCnt, bCnt;
   int          awBeforeW = 0;
   int          doneIfCnt = 0;
   int          doneDCnt  = 0;
   logic [31:0] lastAraddr = 32'h0;
   bit          prevIfReq = 0, prevDReq = 0, prevDWe = 0;
   logic [31:0] prevIfAddr, prevDAddr, prevDWdata;
   logic [3:0]  prevDWstrb;

   mem_arbiter #(.DATA_W(32), .STRB_W(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .axi_arprot(axi_arprot), .axi_awprot(axi_awprot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit roll();
      return $urandom_range(0, 99) < readyPct;
   endfunction

   function automatic logic [1:0] pickResp();
      if (forceRespEn) return forceResp;
      if ($urandom_range(0, 99) < errPct) return 2'($urandom_range(1, 3));
      return 2'b00;
   endfunction

   // AXI4-Lite slave; resets together with the arbiter.
   initial begin : slave
      bit sRst, hsAr, hsR, hsAw, hsW, hsB, rPend, bPend, awGot, wGot;
      rPend = 0; bPend = 0; awGot = 0; wGot = 0;
      axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0;
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
      forever begin
         @(negedge clk);
         sRst = rst;
         hsAr = axi_arvalid && axi_arready;
         hsR  = axi_rvalid && axi_rready;
         hsAw = axi_awvalid && axi_awready;
         hsW  = axi_wvalid && axi_wready;
         hsB  = axi_bvalid && axi_bready;
         @(posedge clk);
         #1;
         if (sRst) begin
            rPend = 0; bPend = 0; awGot = 0; wGot = 0;
            axi_rvalid = 0; axi_bvalid = 0; axi_arready = 0; axi_awready = 0; axi_wready = 0;
         end else begin
            if (hsAr) rPend = 1;
            if (hsR) axi_rvalid = 0;
            if (hsAw) awGot = 1;
            if (hsW) wGot = 1;
            if (awGot && wGot) begin bPend = 1; awGot = 0; wGot = 0; end
            if (hsB) axi_bvalid = 0;
            if (rPend && !axi_rvalid) begin
               if (rHold > 0) rHold--;
               else if (roll()) begin
                  axi_rvalid = 1;
                  axi_rdata  = forceRdEn ? forceRdata : $urandom;
                  axi_rresp  = pickResp();
                  rPend      = 0;
               end
            end
            if (bPend && !axi_bvalid && roll()) begin
               axi_bvalid = 1;
               axi_bresp  = pickResp();
               bPend      = 0;
            end
            axi_arready = roll();
            axi_awready = roll();
            if (axi_wvalid && wHold > 0) begin
               axi_wready = 0;
               wHold--;
            end else begin
               axi_wready = roll();
            end
         end
      end
   end

   // Transaction-level model: idle gap, grant choice, one handshake per channel, completion.
   initial begin : compare
      int  ph;
      bit  gnt;
      forever begin
         @(negedge clk);
         if (rst) begin
            phase = 2;
            lastGntData = 0;
         end else begin
            ph = phase;
            if (ph == 2) begin
               checkOutput("idle_after_resp",
                  {axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready, if_done, d_done}, 0);
               phase = 0;
            end
            if (ph == 0) begin
               if (prevIfReq || prevDReq) begin
                  gnt   = (prevIfReq && prevDReq) ? !lastGntData : prevDReq;
                  expWe = gnt && prevDWe;
                  checkOutput("start", {axi_arvalid, axi_awvalid, axi_wvalid}, expWe ? 3'b011 : 3'b100);
                  expAddr  = (gnt ? prevDAddr : prevIfAddr) & 32'hFFFF_FFFC;
                  expWdata = prevDWdata;
                  expWstrb = prevDWstrb;
                  arCnt = 0; rCnt = 0; awCnt = 0; wCnt = 0; bCnt = 0;
                  gntData = gnt;
                  lastGntData = gnt;
                  phase = 1;
               end else begin
                  checkOutput("idle_quiet", {axi_arvalid, axi_awvalid, axi_wvalid, if_done, d_done}, 0);
               end
            end
            if (phase == 1) begin
               if (axi_arvalid && axi_arready) begin
                  arCnt++;
                  lastAraddr = axi_araddr;
                  checkOutput("araddr", axi_araddr, expAddr);
               end
               if (axi_rvalid && axi_rready) begin
                  rCnt++;
                  expRdata = axi_rdata;
                  expErr   = (axi_rresp != 2'b00);
               end
               if (axi_awvalid && axi_awready) begin
                  awCnt++;
                  checkOutput("awaddr", axi_awaddr, expAddr);
               end
               if (axi_wvalid && axi_wready) begin
                  wCnt++;
                  checkOutput("wdata", axi_wdata, expWdata);
                  checkOutput("wstrb", {28'h0, axi_wstrb}, {28'h0, expWstrb});
               end
               if (axi_bvalid && axi_bready) begin
                  bCnt++;
                  expRdata = 32'h0;
                  expErr   = (axi_bresp != 2'b00);
               end
               if (!axi_awvalid && axi_wvalid) awBeforeW++;
               if (if_done || d_done) begin
                  checkOutput("done_port", {if_done, d_done}, gntData ? 2'b01 : 2'b10);
                  checkOutput("done_rdata", gntData ? d_rdata : if_rdata, expRdata);
                  checkOutput("done_err", gntData ? d_err : if_err, expErr);
                  checkOutput("hs_counts", {arCnt[3:0], rCnt[3:0], awCnt[3:0], wCnt[3:0], bCnt[3:0]},
                              expWe ? 32'h00111 : 32'h11000);
                  if (if_done) doneIfCnt++;
                  if (d_done) doneDCnt++;
                  phase = 2;
               end
            end
         end
         prevIfReq  = if_req;
         prevDReq   = d_req;
         prevDWe    = d_we;
         prevIfAddr = if_addr;
         prevDAddr  = d_addr;
         prevDWdata = d_wdata;
         prevDWstrb = d_wstrb;
      end
   end

   // One access from a port; lat is the cycle of done counting the request cycle as 1.
   task automatic applyStimulus(input bit port, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                output logic [31:0] rdata, output bit err, output int lat);
      bit got = 0;
      int n = 1;
      @(posedge clk);
      #1;
      if (port) begin
         d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = strb;
      end else begin
         if_req = 1; if_addr = addr;
      end
      rdata = 32'h0; err = 0;
      while (!got && n < 300) begin
         @(negedge clk);
         if (port ? d_done : if_done) begin
            got = 1;
            rdata = port ? d_rdata : if_rdata;
            err = port ? d_err : if_err;
         end else begin
            n++;
         end
      end
      lat = n;
      checkOutput(port ? "d_timeout" : "if_timeout", got, 1);
      @(posedge clk);
      #1;
      if (port) d_req = 0;
      else if_req = 0;
   endtask

   initial begin : main
      logic [31:0] rd, rd2;
      bit          e, e2;
      int          lat, lat2, base, cnt, n, t1, t2;
      rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_handshake", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 0);
      checkOutput("rst_addr", axi_araddr | axi_awaddr, 0);
      checkOutput("rst_wdata", axi_wdata, 0);
      checkOutput("rst_wstrb", {28'h0, axi_wstrb}, 0);
      checkOutput("rst_done_err", {if_done, d_done, if_err, d_err}, 0);
      checkOutput("rst_rdata", if_rdata | d_rdata, 0);
      checkOutput("prot", {axi_arprot, axi_awprot}, 0);
      @(posedge clk);
      #1 rst = 0;

      // Zero-wait fetch of an unaligned address
      forceRdEn = 1; forceRdata = 32'hDEADBEEF;
      applyStimulus(0, 0, 32'h0000_1003, 0, 0, rd, e, lat);
      forceRdEn = 0;
      checkOutput("fetch_araddr", lastAraddr, 32'h0000_1000);
      checkOutput("fetch_lat", lat, 4);
      checkOutput("fetch_rdata", rd, 32'hDEADBEEF);
      checkOutput("fetch_err", e, 0);

      // Two simultaneous requests, twice: data first, fetch next
      for (int round = 0; round < 2; round++) begin
         fork
            applyStimulus(0, 0, 32'h0000_2000, 0, 0, rd, e, lat);
            applyStimulus(1, 0, 32'h0000_3004, 0, 0, rd2, e2, lat2);
         join
         checkOutput("tie_data_lat", lat2, 4);
         checkOutput("tie_fetch_lat", lat, 8);
      end

      // Store with write data accepted three cycles after the address
      base = doneDCnt; awBeforeW = 0; wHold = 3;
      applyStimulus(1, 1, 32'h0000_5001, 32'h0000AB00, 4'b0010, rd, e, lat);
      repeat (6) @(negedge clk);
      checkOutput("store_w_after_aw", awBeforeW, 3);
      checkOutput("store_rdata", rd, 0);
      checkOutput("store_err", e, 0);
      checkOutput("store_one_done", doneDCnt - base, 1);

      // Load answered with SLVERR
      forceRespEn = 1; forceResp = 2'b10;
      applyStimulus(1, 0, 32'h0000_6000, 0, 0, rd, e, lat);
      forceRespEn = 0;
      checkOutput("load_err", e, 1);
      applyStimulus(1, 0, 32'h0000_6004, 0, 0, rd, e, lat);
      checkOutput("after_err_lat", lat, 4);

      // Reset while waiting in R abandons the fetch silently
      base = doneIfCnt; rHold = 6;
      @(posedge clk);
      #1 if_req = 1; if_addr = 32'h0000_7000;
      n = 0;
      do begin @(negedge clk); n++; end while (!axi_rready && n < 20);
      checkOutput("reached_r", axi_rready, 1);
      @(posedge clk);
      #1 rst = 1; if_req = 0;
      @(posedge clk);
      #1 rst = 0; rHold = 0;
      @(negedge clk);
      checkOutput("rst_mid_rready", axi_rready, 0);
      checkOutput("rst_mid_no_done", doneIfCnt - base, 0);
      applyStimulus(0, 0, 32'h0000_7008, 0, 0, rd, e, lat);
      checkOutput("post_rst_lat", lat, 4);

      // Request held through done plus one cycle gives two back-to-back accesses
      base = doneDCnt; cnt = 0; n = 0; t1 = 0; t2 = 0;
      @(posedge clk);
      #1 d_req = 1; d_we = 0; d_addr = 32'h0000_4008;
      while (cnt < 2 && n < 100) begin
         @(negedge clk);
         n++;
         if (d_done) begin
            cnt++;
            if (cnt == 1) t1 = n; else t2 = n;
         end
      end
      @(posedge clk);
      #1 d_req = 0;
      repeat (6) @(negedge clk);
      checkOutput("held_two_done", doneDCnt - base, 2);
      checkOutput("held_gap", t2 - t1, 4);

      // Randomized traffic
      readyPct = 60; errPct = 15;
      fork
         begin : fetchLoop
            logic [31:0] frd; bit fe; int fl;
            for (int i = 0; i < 30; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               applyStimulus(0, 0, $urandom, 0, 0, frd, fe, fl);
            end
         end
         begin : dataLoop
            logic [31:0] drd; bit de; int dl;
            for (int j = 0; j < 30; j++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               applyStimulus(1, 1'($urandom), $urandom, $urandom, 4'($urandom), drd, de, dl);
            end
         end
      join
      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin : watchdog
      #1_000_000;
      failCount++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
